// File: rtl/spram.sv
// Single-port synchronous scratch RAM with a shared bidirectional data bus.
// Writes sample the bus; reads return the addressed word one clock later.
module spram #(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 32,
    parameter int Depth     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AddrWidth-1:0] addr,
    inout  wire  [DataWidth-1:0] data,
    input  logic                 cs,
    input  logic                 wr,
    input  logic                 rd
);

    localparam logic [AddrWidth:0] DepthLim = Depth[AddrWidth:0];

    logic [DataWidth-1:0] mem_q [0:Depth-1];
    logic [DataWidth-1:0] mem_d [0:Depth-1];
    logic [DataWidth-1:0] rd_data_q;
    logic [DataWidth-1:0] rd_data_d;
    logic                 addr_ok;
    logic                 wr_en;
    logic                 rd_en;
    logic                 drive_en;

    // Strobe decode; simultaneous wr and rd is treated as neither.
    always_comb begin
        addr_ok  = ({1'b0, addr} < DepthLim);
        wr_en    = cs & wr & ~rd;
        rd_en    = cs & rd & ~wr;
        drive_en = rd_en & ~rst;
    end

    // Next-state memory contents: only an in-range legal write changes a word.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && addr_ok) begin
            mem_d[addr] = data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Next-state read register: holds unless a legal read is issued.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (addr_ok) begin
                rd_data_d = mem_q[addr];
            end else begin
                rd_data_d = {DataWidth{1'b0}};
            end
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State registers with asynchronous clear of the whole array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= {DataWidth{1'b0}};
            end
            rd_data_q <= {DataWidth{1'b0}};
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Bus is released whenever the agent is not reading, including during reset.
    assign data = drive_en ? rd_data_q : {DataWidth{1'bz}};

endmodule

// File: tb/tb_spram.sv
// Randomized and directed self-checking bench for spram against a behavioural model.
module tb_spram;

    logic        clk;
    logic        rst;
    logic [3:0]  addr;
    wire  [31:0] data;
    logic        cs;
    logic        wr;
    logic        rd;
    logic        drv_en;
    logic [31:0] drv_val;

    int          n_total;
    int          n_pass;

    logic [31:0] m_mem [16];
    logic [31:0] m_rd;

    logic [31:0] wvals [10] = '{32'h12153524, 32'hC0895E81, 32'h8484D609, 32'hB1F05663,
                                32'h06B97B0D, 32'h46DF998D, 32'hB2C28465, 32'h89375212,
                                32'h00F3E301, 32'h06D7CD0D};

    assign data = drv_en ? drv_val : 32'bz;

    spram #(.AddrWidth(4), .DataWidth(32), .Depth(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data),
        .cs   (cs),
        .wr   (wr),
        .rd   (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain word array plus the last-read word.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] <= 32'h0;
            m_rd <= 32'h0;
        end else if (cs && wr && !rd) begin
            m_mem[addr] <= data;
        end else if (cs && rd && !wr) begin
            m_rd <= m_mem[addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: the RAM must show the model's read word, or leave the bench's drive intact.
    always @(negedge clk) begin
        if (!rst) begin
            if (cs && rd && !wr) chk("bus_read", data, m_rd);
            else if (drv_en)     chk("bus_release", data, drv_val);
        end
    end

    task automatic drive(input logic c, input logic w, input logic r,
                         input logic [3:0] a, input logic [31:0] v);
        @(posedge clk);
        #1;
        cs      = c;
        wr      = w;
        rd      = r;
        addr    = a;
        drv_val = v;
        drv_en  = !(c && r && !w);
    endtask

    task automatic rd_lit(input logic [3:0] a, input logic [31:0] exp, input string name);
        drive(1'b1, 1'b0, 1'b1, a, 32'h0);
        drive(1'b1, 1'b0, 1'b1, a, 32'h0);
        @(negedge clk);
        chk(name, data, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        cs      = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        addr    = 4'd0;
        drv_en  = 1'b1;
        drv_val = 32'hA5A5A5A5;
        #12;
        chk("reset_bus_z", data, 32'hA5A5A5A5);
        #11;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) rd_lit(4'(i), 32'h0, "reset_read");

        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 4'(i), wvals[i]);
        rd_lit(4'd0, 32'h12153524, "readback_0");
        rd_lit(4'd1, 32'hC0895E81, "readback_1");
        for (int i = 2; i < 10; i++) rd_lit(4'(i), wvals[i], "readback");
        for (int i = 10; i < 16; i++) rd_lit(4'(i), 32'h0, "untouched");

        drive(1'b0, 1'b0, 1'b1, 4'd1, 32'h0F0F0F0F);
        @(negedge clk);
        chk("release_cs0", data, 32'h0F0F0F0F);

        drive(1'b1, 1'b1, 1'b1, 4'd3, 32'hDEADBEEF);
        @(negedge clk);
        chk("release_illegal", data, 32'hDEADBEEF);
        rd_lit(4'd3, 32'hB1F05663, "illegal_no_write");
        drive(1'b0, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
        rd_lit(4'd3, 32'hB1F05663, "deselect_no_write");

        drive(1'b1, 1'b1, 1'b0, 4'd15, 32'hAAAAAAAA);
        drive(1'b1, 1'b1, 1'b0, 4'd15, 32'h55555555);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h00000000);
        @(negedge clk);
        chk("hold_before_read", m_rd, 32'hB1F05663);
        drive(1'b1, 1'b0, 1'b1, 4'd0, 32'h0);
        #1;
        chk("enable_shows_last", data, 32'hB1F05663);
        rd_lit(4'd15, 32'h55555555, "overwrite");

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end

        drive(1'b1, 1'b0, 1'b1, 4'd0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 4'd1, 32'h0);
        @(posedge clk);
        #3;
        rst     = 1'b1;
        drv_en  = 1'b1;
        drv_val = 32'h0F0F0F0F;
        #1;
        chk("async_rst_bus_z", data, 32'h0F0F0F0F);
        #1;
        rst    = 1'b0;
        drv_en = 1'b0;
        #1;
        chk("rst_clears_rd_reg", data, 32'h0);
        for (int i = 0; i < 16; i++) rd_lit(4'(i), 32'h0, "post_rst_read");

        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
